// File: rtl/bp_be_stride_pf_sched.sv
// Prefetch issue scheduler: tracks confirmed-stride streams and shares one D$ prefetch port
// between them round-robin. Optional macro BP_BE_PF_PAGE_GUARD_EN keeps streams inside a 4 KiB page.
module bp_be_stride_pf_sched #(
  parameter int streams_p      = 4,
  parameter int depth_p        = 4,
  parameter int stride_width_p = 8,
  parameter int vaddr_width_p  = 39
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             enable_i,
  input  logic                             flush_i,
  input  logic                             train_v_i,
  input  logic [vaddr_width_p-1:0]         train_pc_i,
  input  logic [vaddr_width_p-1:0]         train_addr_i,
  input  logic [stride_width_p-1:0]        train_stride_i,
  output logic                             pf_v_o,
  output logic [vaddr_width_p-1:0]         pf_addr_o,
  input  logic                             pf_ready_i,
  output logic [$clog2(streams_p+1)-1:0]   active_streams_o,
  output logic                             dbg_state_o
);

  localparam int idx_w_lp  = (streams_p > 1) ? $clog2(streams_p) : 1;
  localparam int cred_w_lp = $clog2(depth_p + 1);
  localparam int cnt_w_lp  = $clog2(streams_p + 1);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_e;
  state_e r_state, w_state_n;

  logic [streams_p-1:0]     r_v;
  logic [vaddr_width_p-1:0] r_pc     [streams_p];
  logic [vaddr_width_p-1:0] r_next   [streams_p];
  logic [vaddr_width_p-1:0] r_stride [streams_p];
  logic [cred_w_lp-1:0]     r_credit [streams_p];
`ifdef BP_BE_PF_PAGE_GUARD_EN
  logic [vaddr_width_p-13:0] r_page  [streams_p];
`endif
  logic [idx_w_lp-1:0]      r_rr, r_victim, r_win;
  logic                     r_stale;
  logic [vaddr_width_p-1:0] r_pf_addr;
  logic [cnt_w_lp-1:0]      r_active;

  logic                     w_train, w_hit, w_has_free, w_replace;
  logic [idx_w_lp-1:0]      w_hit_idx, w_free_idx, w_tgt_idx;
  logic [vaddr_width_p-1:0] w_train_stride;
  logic [streams_p-1:0]     w_elig, w_off_page;
  logic                     w_found, w_launch, w_hs;
  logic [idx_w_lp-1:0]      w_pick, w_scan;
  logic [cnt_w_lp-1:0]      w_pop;

  assign w_train_stride = {{(vaddr_width_p-stride_width_p){train_stride_i[stride_width_p-1]}},
                           train_stride_i};
  assign w_train = train_v_i & ~flush_i & (train_stride_i != '0);

  // Descending scan so the lowest matching / free index is the one kept.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_has_free = 1'b0;
    w_free_idx = '0;
    for (int i = streams_p - 1; i >= 0; i--) begin
      if (r_v[i] && (r_pc[i] == train_pc_i)) begin
        w_hit     = 1'b1;
        w_hit_idx = idx_w_lp'(i);
      end
      if (!r_v[i]) begin
        w_has_free = 1'b1;
        w_free_idx = idx_w_lp'(i);
      end
    end
    w_replace = ~w_hit & ~w_has_free;
    w_tgt_idx = w_hit ? w_hit_idx : (w_has_free ? w_free_idx : r_victim);
  end

  always_comb begin
    w_elig     = '0;
    w_off_page = '0;
    w_pop      = '0;
    for (int i = 0; i < streams_p; i++) begin
`ifdef BP_BE_PF_PAGE_GUARD_EN
      w_off_page[i] = (r_next[i][vaddr_width_p-1:12] != r_page[i]);
`endif
      w_elig[i] = r_v[i] & (r_credit[i] != '0) & ~w_off_page[i];
      w_pop     = w_pop + cnt_w_lp'(r_v[i]);
    end
  end

  // Round-robin pick: first eligible entry at or after the rr pointer.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_scan  = '0;
    for (int k = 0; k < streams_p; k++) begin
      w_scan = idx_w_lp'((int'(r_rr) + k) % streams_p);
      if (!w_found && w_elig[w_scan]) begin
        w_found = 1'b1;
        w_pick  = w_scan;
      end
    end
  end

  // pf_v_o/pf_ready_i: request held stable while valid; transfer on valid & ready; never withdrawn except by flush.
  always_comb begin
    w_state_n = r_state;
    w_launch  = 1'b0;
    w_hs      = 1'b0;
    case (r_state)
      S_IDLE: if (enable_i && w_found) begin
        w_launch  = 1'b1;
        w_state_n = S_REQ;
      end
      S_REQ: if (pf_ready_i) begin
        w_hs      = 1'b1;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
    if (flush_i) begin
      w_launch  = 1'b0;
      w_state_n = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= S_IDLE;
    else            r_state <= w_state_n;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_v       <= '0;
      r_rr      <= '0;
      r_victim  <= '0;
      r_win     <= '0;
      r_stale   <= 1'b0;
      r_pf_addr <= '0;
      r_active  <= '0;
      for (int i = 0; i < streams_p; i++) begin
        r_pc[i]     <= '0;
        r_next[i]   <= '0;
        r_stride[i] <= '0;
        r_credit[i] <= '0;
`ifdef BP_BE_PF_PAGE_GUARD_EN
        r_page[i]   <= '0;
`endif
      end
    end else begin
      r_active <= w_pop;
      if (flush_i) begin
        r_v     <= '0;
        r_stale <= 1'b0;
      end else begin
        if (w_hs) begin
          r_rr <= (r_win == idx_w_lp'(streams_p - 1)) ? '0 : r_win + idx_w_lp'(1);
          // A stale winner was replaced under the request; a same-cycle retrain wins over the decrement.
          if (!r_stale && !(w_train && (w_tgt_idx == r_win))) begin
            r_next[r_win] <= r_next[r_win] + r_stride[r_win];
            if (r_credit[r_win] != '0) r_credit[r_win] <= r_credit[r_win] - cred_w_lp'(1);
          end
        end
        for (int i = 0; i < streams_p; i++) begin
          if (w_off_page[i]) r_credit[i] <= '0;
        end
        if (w_launch) begin
          r_win     <= w_pick;
          r_pf_addr <= r_next[w_pick];
          r_stale   <= 1'b0;
        end
        if (w_train) begin
          r_v[w_tgt_idx]      <= 1'b1;
          r_pc[w_tgt_idx]     <= train_pc_i;
          r_next[w_tgt_idx]   <= train_addr_i + w_train_stride;
          r_stride[w_tgt_idx] <= w_train_stride;
          r_credit[w_tgt_idx] <= cred_w_lp'(depth_p);
`ifdef BP_BE_PF_PAGE_GUARD_EN
          r_page[w_tgt_idx]   <= train_addr_i[vaddr_width_p-1:12];
`endif
          if (w_replace) begin
            r_victim <= (r_victim == idx_w_lp'(streams_p - 1)) ? '0 : r_victim + idx_w_lp'(1);
            if ((w_launch && (w_tgt_idx == w_pick)) || ((r_state == S_REQ) && (w_tgt_idx == r_win)))
              r_stale <= 1'b1;
          end
        end
      end
    end
  end

  assign pf_v_o           = (r_state == S_REQ);
  assign pf_addr_o        = r_pf_addr;
  assign active_streams_o = r_active;
  assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_bp_be_stride_pf_sched.sv
// Randomized and directed bench for bp_be_stride_pf_sched with an in-bench stream-table model.
module tb_bp_be_stride_pf_sched;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int SW = 8;
  localparam int V  = 39;
  localparam int AW = $clog2(N + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0, flush = 1'b0, train_v = 1'b0, pf_ready = 1'b0;
  logic [V-1:0] train_pc = '0, train_addr = '0;
  logic [SW-1:0] train_stride = '0;
  logic pf_v, dbg_state;
  logic [V-1:0] pf_addr;
  logic [AW-1:0] active;

  int n_cmp = 0;
  int n_fail = 0;
  logic [V-1:0] got_q[$];
  logic [V-1:0] exp_q[$];

  always #5 clk = ~clk;

  bp_be_stride_pf_sched #(.streams_p(N), .depth_p(D), .stride_width_p(SW), .vaddr_width_p(V)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .enable_i(enable), .flush_i(flush),
    .train_v_i(train_v), .train_pc_i(train_pc), .train_addr_i(train_addr),
    .train_stride_i(train_stride), .pf_v_o(pf_v), .pf_addr_o(pf_addr),
    .pf_ready_i(pf_ready), .active_streams_o(active), .dbg_state_o(dbg_state)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stream table, victim/rr pointers and the one outstanding request.
  typedef struct {
    logic v; logic [V-1:0] pc; logic [V-1:0] nxt; logic [V-1:0] strd; int cred; logic [V-1:0] taddr;
  } ent_t;
  ent_t m_e[N];
  int m_rr, m_victim, m_held, m_active;
  bit m_busy, m_stale;
  logic [V-1:0] m_addr;

  function automatic bit m_off(input int i);
`ifdef BP_BE_PF_PAGE_GUARD_EN
    return (m_e[i].nxt >> 12) != (m_e[i].taddr >> 12);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit hs, launch, trn, hit, repl, busy0;
    int pick, tidx, cnt, j;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_e[i] = '{1'b0, '0, '0, '0, 0, '0};
      m_rr = 0; m_victim = 0; m_held = 0; m_active = 0;
      m_busy = 0; m_stale = 0; m_addr = '0;
    end else begin
      cnt = 0;
      for (int i = 0; i < N; i++) if (m_e[i].v) cnt++;
      busy0 = m_busy;
      hs = m_busy && pf_ready;
      launch = 0; pick = 0;
      if (!m_busy && enable)
        for (int k = 0; k < N; k++) begin
          j = (m_rr + k) % N;
          if (!launch && m_e[j].v && m_e[j].cred > 0 && !m_off(j)) begin launch = 1; pick = j; end
        end
      trn = train_v && (train_stride != 0);
      hit = 0; tidx = -1; repl = 0;
      for (int i = 0; i < N; i++)
        if (!hit && m_e[i].v && m_e[i].pc == train_pc) begin hit = 1; tidx = i; end
      if (!hit)
        for (int i = 0; i < N; i++) if (tidx < 0 && !m_e[i].v) tidx = i;
      if (tidx < 0) begin tidx = m_victim; repl = 1; end
      if (flush) begin
        for (int i = 0; i < N; i++) m_e[i].v = 1'b0;
        m_busy = 0; m_stale = 0;
      end else begin
        if (hs) begin
          if (!m_stale && !(trn && tidx == m_held)) begin
            m_e[m_held].nxt = m_e[m_held].nxt + m_e[m_held].strd;
            if (m_e[m_held].cred > 0) m_e[m_held].cred--;
          end
          m_rr = (m_held + 1) % N;
          m_busy = 0;
        end
        for (int i = 0; i < N; i++) if (m_e[i].cred > 0 && m_off(i)) m_e[i].cred = 0;
        if (launch) begin m_busy = 1; m_held = pick; m_addr = m_e[pick].nxt; m_stale = 0; end
        if (trn) begin
          if (repl) begin
            m_victim = (m_victim + 1) % N;
            if ((launch && tidx == pick) || (busy0 && tidx == m_held)) m_stale = 1;
          end
          m_e[tidx].v = 1'b1;
          m_e[tidx].pc = train_pc;
          m_e[tidx].strd = V'($signed(train_stride));
          m_e[tidx].nxt = train_addr + V'($signed(train_stride));
          m_e[tidx].cred = D;
          m_e[tidx].taddr = train_addr;
        end
      end
      m_active = cnt;
    end
  end

  // Per-cycle comparison against the model plus capture of accepted requests.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_pf_v", 64'(pf_v), 64'd0);
      chk("rst_pf_addr", 64'(pf_addr), 64'd0);
      chk("rst_active", 64'(active), 64'd0);
    end else begin
      chk("pf_v", 64'(pf_v), 64'(m_busy));
      if (m_busy) chk("pf_addr", 64'(pf_addr), 64'(m_addr));
      chk("active", 64'(active), 64'(m_active));
      if (pf_v && pf_ready) got_q.push_back(pf_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic train(input logic [V-1:0] pc, input logic [V-1:0] addr, input logic [SW-1:0] s);
    train_v = 1'b1; train_pc = pc; train_addr = addr; train_stride = s;
    tick();
    train_v = 1'b0; train_stride = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; train_v = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_seq(input string name);
    chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk(name, (i < got_q.size()) ? 64'(got_q[i]) : 64'hx, 64'(exp_q[i]));
  endtask

  initial begin
    logic [63:0] r64;
    bit seen;
    logic [V-1:0] held;

    // Reset with inputs toggling
    for (int c = 0; c < 6; c++) begin
      enable = 1'($urandom); flush = 1'($urandom); train_v = 1'($urandom);
      pf_ready = 1'($urandom); train_pc = V'($urandom); train_addr = V'($urandom);
      train_stride = SW'($urandom);
      tick();
      chk("reset_pf_v", 64'(pf_v), 64'd0);
      chk("reset_active", 64'(active), 64'd0);
    end
    enable = 1'b0; flush = 1'b0; train_v = 1'b0; train_stride = '0; pf_ready = 1'b1;
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (5) tick();
    chk("idle_pf_v", 64'(pf_v), 64'd0);

    // Single stream, positive stride
    got_q.delete();
    train(V'(32'h100), V'(32'h8000), 8'h40);
    repeat (20) tick();
    exp_q = '{V'(32'h8040), V'(32'h8080), V'(32'h80C0), V'(32'h8100)};
    check_seq("single");
    chk("single_done_pf_v", 64'(pf_v), 64'd0);
    chk("single_active", 64'(active), 64'd1);

    // Negative stride with wrap below zero
    got_q.delete();
    train(V'(32'h200), V'(32'h20), 8'hF0);
    repeat (20) tick();
    exp_q = '{V'(32'h10), V'(0), {V{1'b1}} - V'(32'hF), {V{1'b1}} - V'(32'h1F)};
    check_seq("negwrap");

    // Round-robin across four streams, then eviction of entry 0
    do_reset();
    got_q.delete();
    for (int i = 0; i < N; i++) train(V'(32'h1000 + i), V'(32'h10000 * (i + 1)), 8'd8);
    repeat (45) tick();
    exp_q.delete();
    for (int r = 0; r < D; r++)
      for (int i = 0; i < N; i++) exp_q.push_back(V'(32'h10000 * (i + 1) + 8 * (r + 1)));
    check_seq("rr");
    chk("rr_active", 64'(active), 64'd4);
    got_q.delete();
    train(V'(32'h2000), V'(32'h50000), 8'd8);
    repeat (15) tick();
    exp_q = '{V'(32'h50008), V'(32'h50010), V'(32'h50018), V'(32'h50020)};
    check_seq("evict");
    chk("evict_active", 64'(active), 64'd4);

    // Backpressure hold, then flush
    pf_ready = 1'b0;
    train(V'(32'h3000), V'(32'hA000), 8'h10);
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      if (pf_v) seen = 1'b1;
      else tick();
    end
    chk("bp_req_seen", 64'(seen), 64'd1);
    held = pf_addr;
    chk("bp_first_addr", 64'(held), 64'(V'(32'hA010)));
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_hold_v", 64'(pf_v), 64'd1);
      chk("bp_hold_addr", 64'(pf_addr), 64'(V'(32'hA010)));
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_pf_v", 64'(pf_v), 64'd0);
    chk("flush_active_lag", 64'(active), 64'd4);
    tick();
    chk("flush_active", 64'(active), 64'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      r64 = {$urandom, $urandom};
      train_v = ($urandom_range(0, 3) == 0);
      train_pc = V'(32'h100 + $urandom_range(0, 5));
      train_addr = r64[V-1:0];
      train_stride = ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom);
      pf_ready = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 99) == 0);
      tick();
    end
    train_v = 1'b0; train_stride = '0; flush = 1'b0; enable = 1'b1; pf_ready = 1'b1;
    repeat (10) tick();

    // Page-crossing stream
    do_reset();
    got_q.delete();
    train(V'(32'h700), V'(32'h8FC0), 8'h40);
    repeat (20) tick();
`ifdef BP_BE_PF_PAGE_GUARD_EN
    exp_q.delete();
`else
    exp_q = '{V'(32'h9000), V'(32'h9040), V'(32'h9080), V'(32'h90C0)};
`endif
    check_seq("page");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/bp_be_stride_pf_sched.md
Name: bp_be_stride_pf_sched

Overview:
- Prefetch issue scheduler downstream of the backend stride-detection table.
- Takes confirmed-stride training events (pc, effective address, stride) and keeps a small table of active streams.
- Shares one prefetch request port to the D$ between those streams using a round-robin arbiter.
- Each stream runs at most depth_p prefetches ahead of its last trained access.

Parameters:
- streams_p, 4, number of concurrent stream entries.
- depth_p, 4, prefetches issued per stream per training event (credit refill value).
- stride_width_p, 8, width of the incoming stride; two's complement, signed.
- vaddr_width_p, from bp_params_p, virtual address width.

Ports:
- clk_i  in  1  clock; all state sampled on posedge.
- reset_n_i  in  1  one clock; reset is asynchronous and active-low.
- enable_i  in  1  when 0, no new prefetch is launched; a held request still completes.
- flush_i  in  1  invalidate all streams and drop any unaccepted request.
- train_v_i  in  1  training event valid; single-cycle pulse, no backpressure.
- train_pc_i  in  vaddr_width_p  pc of the striding load.
- train_addr_i  in  vaddr_width_p  effective address of that load.
- train_stride_i  in  stride_width_p  signed stride in bytes.
- pf_v_o  out  1  prefetch request valid.
- pf_addr_o  out  vaddr_width_p  prefetch virtual address.
- pf_ready_i  in  1  consumer accepts; handshake = pf_v_o & pf_ready_i.
- active_streams_o  out  clog2(streams_p+1)  count of valid entries.

Behaviour:
- Entry fields: v, pc (full vaddr), next_addr, stride (sign-extended to vaddr_width_p), credit (0..depth_p).
- Reset (async assert, sync release): all entries invalid, rr pointer 0, victim pointer 0, pf_v_o=0, pf_addr_o=0, active_streams_o=0.
- Training with train_stride_i==0 is ignored: no allocate, no update.
- Train hit (valid entry with pc == train_pc_i), applied next edge:
  - next_addr <= train_addr_i + sext(stride)
  - stride <= sext(train_stride_i)
  - credit <= depth_p
- Train miss: allocate the lowest-index invalid entry with the same field values and v=1.
  - If no entry is invalid, replace the entry at the victim pointer, then increment the victim pointer modulo streams_p.
- Address arithmetic is modulo 2^vaddr_width_p; wrap-around is permitted and not flagged.
- Issue FSM has two states:
  - IDLE: pf_v_o=0. If enable_i and some entry has v & credit>0, select via round-robin starting at the rr pointer. Latch pf_addr_o=next_addr of the winner and the winner index, then go to REQ.
  - REQ: pf_v_o=1, with pf_addr_o and the winner index held stable until handshake.
  - On handshake: winner next_addr += stride, credit -= 1, rr pointer <= winner+1 mod streams_p, go to IDLE.
  - Throughput: at most one request per 2 cycles.
- Latency: train_v_i at cycle t → table updated at edge t+1 → pf_v_o asserted from cycle t+2 (if IDLE and enabled).
- Simultaneous handshake and train hit on the same entry: train update wins; the handshake decrement is discarded.
- Train replacement of the entry currently held in REQ: the held request still completes; no table update on its handshake.
- Credit reaching 0: entry stays valid but is not eligible until retrained.
- flush_i has highest priority:
  - Next edge: all entries invalid, FSM to IDLE, pf_v_o=0.
  - A handshake in the flush cycle counts as accepted by the consumer, but the table is not updated.
  - A train_v_i in the flush cycle is dropped.
- enable_i=0 in REQ does not withdraw the request.
- active_streams_o is a registered popcount of v and updates the cycle after the table changes.

Optional Feature:
- Macro: BP_BE_PF_PAGE_GUARD_EN.
- When defined: a prefetch whose next_addr[vaddr-1:12] differs from the page of the last trained address of that stream is not issued. The entry's credit is forced to 0 instead, so the stream never crosses a 4 KiB page boundary.
- When undefined: no page check; streams run across pages.

Test Plan:
- Reset/idle: hold reset_n_i=0, toggle all inputs → pf_v_o=0, pf_addr_o=0, active_streams_o=0. Release reset with no training → pf_v_o stays 0.
- Single stream: train pc=0x100, addr=0x8000, stride=+64, pf_ready_i=1 → four requests 0x8040, 0x8080, 0x80C0, 0x8100, then pf_v_o=0 until retrained.
- Negative stride/wrap: train addr=0x20, stride=-16 (0xF0) → requests 0x10, 0x0, then 2^vaddr-0x10.
- Arbitration: train 4 pcs in consecutive cycles, each stride 8, pf_ready_i=1 → requests rotate entries 0,1,2,3,0…; a 5th pc evicts entry 0 (victim ptr 0→1).
- Backpressure/flush: hold pf_ready_i=0 for 10 cycles → pf_v_o/pf_addr_o stable. Assert flush_i → pf_v_o=0 next cycle, active_streams_o=0 one cycle later.
- Page guard (macro on): train addr=0x8FC0, stride=+64 → exactly one request 0x9000 suppressed, zero requests issued. With macro off → 0x9000…0x90C0 issued.
